bus_register_responder: RTL
===========================

# bus_register_responder

Slave-side endpoint of the CPU's strobe/acknowledge bus: a bank of 32-bit registers that answers word reads and writes after a fixed number of wait states. It is the counterpart of the CPU's bus timeout counter. Every mapped access must be acknowledged well inside the master's 256-cycle window. Unmapped accesses are left unacknowledged, so the master's timeout handles them, unless the acknowledge option below is compiled in. It sits on the peripheral side of the bus and serves as the reference responder for bus and timeout verification.

## Interface
- WAIT_STATES, 2: idle cycles inserted between request capture and ack; legal 0..15.
- NUM_REGS, 16: number of mapped registers; legal 1..2^ADDR_WIDTH.
- ADDR_WIDTH, 6: width of the word address.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_stb  in  1  request strobe; the master holds it high until ack or until it abandons the access.
- bus_we  in  1  1 = write, 0 = read; valid while bus_stb is high.
- bus_addr  in  ADDR_WIDTH  word address; valid while bus_stb is high.
- bus_data_in  in  32  write data; valid while bus_stb is high.
- bus_data_out  out  32  read data; nonzero only in the ack cycle of a read.
- bus_ack  out  1  one-cycle completion pulse.

## Operation
- Reset: state IDLE, bus_ack=0, bus_data_out=0, all registers 0, wait counter 0. Reset overrides everything, including an access in progress. No ack is issued for an access cut off by reset, and its write is lost.
- IDLE: bus_stb=1 at an edge captures we, addr and data_in into request registers.
  - Mapped (addr < NUM_REGS): load counter with WAIT_STATES and go to WAIT.
  - Unmapped: go to STALL.
- WAIT: counter decrements once per edge. When counter==0 at an edge, go to ACK.
  - With WAIT_STATES=0, WAIT lasts one cycle.
- ACK: bus_ack=1 for exactly one cycle.
  - Write: register[addr] takes the captured data at the edge that ends the ACK cycle.
  - Read: bus_data_out = register[addr] during the ACK cycle, 0 otherwise.
  - Next state is IDLE.
- STALL: no ack. The block stays here until bus_stb=0, then goes to IDLE.
- Abort: bus_stb=0 while in WAIT or STALL sends the block to IDLE at that edge. No ack is issued and no write is performed. This is the path the master takes after its timeout.
- The master's inputs are sampled only at capture; changes in them during WAIT are ignored.
- Back-to-back: if bus_stb is still high in the cycle after ACK (the IDLE cycle), it is captured as a new request.
- Read after write to the same register returns the new value, because the write commits before the next capture.

## Timing
- bus_stb first seen high in cycle 0 (IDLE). bus_ack is high in cycle WAIT_STATES+2.
  - WAIT_STATES=0: ack in cycle 2.
  - WAIT_STATES=2: ack in cycle 4.
- Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- bus_ack and bus_data_out are registered outputs; no combinational path from any input.
- Worst mapped latency is 17 cycles, well below the 256-cycle master timeout.

## Configuration
- BUS_RESPONDER_UNMAPPED_ACK_EN defined: unmapped accesses follow the same WAIT/ACK path and timing as mapped ones.
  - Reads return 32'h00000000; writes are discarded.
  - STALL is unreachable.
- Not defined: unmapped accesses go to STALL and are never acknowledged, so the master's timeout fires.

## Structure
- Shared package holds:
  - state encoding constants: IDLE, WAIT, ACK, STALL (2 bits);
  - bus data width 32;
  - the unmapped read value.
- Sub-module bus_wait_counter: 4-bit loadable down-counter with load, enable and zero outputs. It is instantiated once.
- The register array, request registers and FSM live in the top module.

## Test plan
- Reset, then write 32'hCAFEF00D to addr 3, then read addr 3 (WAIT_STATES=2) -> each ack arrives in cycle 4 after stb; the read returns 32'hCAFEF00D; bus_data_out=0 outside the ack cycle.
- WAIT_STATES=0, stb held high continuously with alternating addr 0/1 reads -> an ack every 3 cycles, and each ack returns the correct data.
- Without the macro, read addr 20 (NUM_REGS=16) -> no ack for 300 cycles. Drop stb -> IDLE on the next edge, and a following read of addr 0 is acked in cycle 4.
- With the macro, read addr 20 -> ack in cycle 4 with data 0. Write 32'h1234 to addr 20 -> ack; registers 0..15 are unchanged.
- Write to addr 5 with stb dropped in cycle 2 (during WAIT) -> no ack; a later read of addr 5 returns the old value.
- Reset asserted in cycle 2 of a write to addr 7 -> ack never asserted, register 7 reads back 0, and the block accepts a new request the cycle after reset releases.

Source files
------------

// File: rtl/bus_register_responder_pkg.sv
// Shared definitions for the strobe/acknowledge register responder:
// FSM state encoding, bus data width, wait-counter width and the unmapped read value.
package bus_register_responder_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 32;
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  localparam logic [BUS_DATA_WIDTH-1:0] UNMAPPED_READ_VALUE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    STALL = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_register_responder_if.sv
// Strobe/acknowledge bus between the CPU-side master and the register responder.
interface bus_register_responder_if
  import bus_register_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) ();

  logic                      bus_stb;
  logic                      bus_we;
  logic [ADDR_WIDTH-1:0]     bus_addr;
  logic [BUS_DATA_WIDTH-1:0] bus_data_in;
  logic [BUS_DATA_WIDTH-1:0] bus_data_out;
  logic                      bus_ack;

  modport master (
    output bus_stb,
    output bus_we,
    output bus_addr,
    output bus_data_in,
    input  bus_data_out,
    input  bus_ack
  );

  modport slave (
    input  bus_stb,
    input  bus_we,
    input  bus_addr,
    input  bus_data_in,
    output bus_data_out,
    output bus_ack
  );

endinterface

// File: rtl/bus_register_responder_wait_counter.sv
// bus_wait_counter: 4-bit loadable down-counter that times the responder's wait states.
module bus_wait_counter
  import bus_register_responder_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [WAIT_CNT_WIDTH-1:0] i_load_val,
  input  logic                      i_en,
  output logic                      o_zero
);

  logic [WAIT_CNT_WIDTH-1:0] r_count;

  // Saturates at zero so a stray enable can never wrap to 15.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_register_responder.sv
// Register-bank responder on the strobe/acknowledge bus with fixed wait states.
// Define BUS_RESPONDER_UNMAPPED_ACK_EN to acknowledge unmapped accesses instead of stalling.
module bus_register_responder
  import bus_register_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  bus_register_responder_if.slave  bus
);

  localparam int unsigned        IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  bus_state_e                r_state;
  bus_state_e                w_next;

  logic                      r_we;
  logic                      r_mapped;
  logic [IDX_W-1:0]          r_idx;
  logic [BUS_DATA_WIDTH-1:0] r_wdata;
  logic [BUS_DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                      r_ack;
  logic [BUS_DATA_WIDTH-1:0] r_data_out;

  logic                      w_capture;
  logic                      w_addr_mapped;
  logic                      w_cnt_load;
  logic                      w_cnt_en;
  logic                      w_cnt_zero;
  logic [BUS_DATA_WIDTH-1:0] w_read_data;

  assign w_addr_mapped = ({1'b0, bus.bus_addr} < NUM_REGS_W);
  assign w_capture     = (r_state == IDLE) && bus.bus_stb;

  bus_wait_counter u_wait_counter (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_CNT_WIDTH'(WAIT_STATES)),
    .i_en       (w_cnt_en),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort (strobe dropped) takes priority over the counter reaching zero.
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.bus_stb) begin
`ifdef BUS_RESPONDER_UNMAPPED_ACK_EN
          w_next     = WAIT;
          w_cnt_load = 1'b1;
`else
          if (w_addr_mapped) begin
            w_next     = WAIT;
            w_cnt_load = 1'b1;
          end else begin
            w_next = STALL;
          end
`endif
        end
      end
      WAIT: begin
        if (!bus.bus_stb) begin
          w_next = IDLE;
        end else if (w_cnt_zero) begin
          w_next = ACK;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ACK: begin
        w_next = IDLE;
      end
      STALL: begin
        if (!bus.bus_stb) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_mapped <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
    end else if (w_capture) begin
      r_we     <= bus.bus_we;
      r_mapped <= w_addr_mapped;
      r_idx    <= bus.bus_addr[IDX_W-1:0];
      r_wdata  <= bus.bus_data_in;
    end
  end

  // Write commits at the edge closing ACK, so a following capture already sees it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if ((r_state == ACK) && r_we && r_mapped) begin
      r_regs[r_idx] <= r_wdata;
    end
  end

  assign w_read_data = r_mapped ? r_regs[r_idx] : UNMAPPED_READ_VALUE;

  // Outputs are registered one edge ahead of the ACK state they accompany.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ack      <= (w_next == ACK);
      r_data_out <= ((w_next == ACK) && !r_we) ? w_read_data : '0;
    end
  end

  assign bus.bus_ack      = r_ack;
  assign bus.bus_data_out = r_data_out;

endmodule
